// File: rtl/formula_2_res_buf_if.sv
// formula_2_res_buf_if: issue, result, consumer and status signals of the result buffer
interface formula_2_res_buf_if #(parameter int DEPTH = 8, parameter int WIDTH = 32);
  logic arg_issue;
  logic issue_rdy;
  logic res_vld;
  logic [WIDTH-1:0] res;
  logic out_vld;
  logic [WIDTH-1:0] out_data;
  logic out_rdy;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic ovf_err;
  modport master (
    output arg_issue, res_vld, res, out_rdy,
    input issue_rdy, out_vld, out_data, count, ovf_err
  );
  modport slave (
    input arg_issue, res_vld, res, out_rdy,
    output issue_rdy, out_vld, out_data, count, ovf_err
  );
endinterface

// File: rtl/formula_2_res_buf.sv
// formula_2_res_buf: credit-gated circular buffer between a non-stallable formula pipe and a ready/valid consumer.
// Define FORMULA_2_RES_BUF_OVF_CHECK_EN to build the sticky overflow flag.
module formula_2_res_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  formula_2_res_buf_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, credits;
  logic pop, full, wr_en, take;
  always_comb begin
    pop = (count != '0) && bus.out_rdy;
    full = count == CW'(DEPTH);
    wr_en = bus.res_vld && (!full || pop);
    take = bus.arg_issue && (credits != '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      credits <= CW'(DEPTH);
    end else begin
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      wr_ptr <= wr_en ? wr_ptr + PW'(1) : wr_ptr;
      count <= count + CW'(wr_en) - CW'(pop);
      credits <= credits - CW'(take) + CW'(pop);
    end
  end
  // storage is not reset: only the pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.res;
  end
  assign bus.issue_rdy = credits != '0;
  assign bus.out_vld = count != '0;
  assign bus.out_data = mem[rd_ptr];
  assign bus.count = count;
`ifdef FORMULA_2_RES_BUF_OVF_CHECK_EN
  logic ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (bus.res_vld && full && !pop) ovf <= 1'b1;
  end
  assign bus.ovf_err = ovf;
`else
  assign bus.ovf_err = 1'b0;
`endif
endmodule

// File: tb/tb_formula_2_res_buf.sv
// tb_formula_2_res_buf: directed scoreboard bench for formula_2_res_buf at DEPTH=4, WIDTH=32.
module tb_formula_2_res_buf;
  localparam int D = 4;
  localparam int W = 32;
`ifdef FORMULA_2_RES_BUF_OVF_CHECK_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  formula_2_res_buf_if #(.DEPTH(D), .WIDTH(W)) bus ();
  formula_2_res_buf #(.DEPTH(D), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [W-1:0] q[$];
  int mcred = D;
  logic movf = 1'b0;
  int maxc = 0;
  int rdy_drop = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // scoreboard/model update for the coming edge, then the edge, then compare
  task automatic tick();
    bit pop, full;
    pop = bus.out_vld && bus.out_rdy;
    full = q.size() == D;
    if (pop) begin
      if (q.size() != 0) chk("pop_data", bus.out_data, q.pop_front());
      else chk("spurious_pop", bus.out_vld, 1'b0);
    end
    if (bus.res_vld) begin
      if (!full || pop) q.push_back(bus.res);
      else movf = OVF;
    end
    if (bus.arg_issue && mcred != 0) mcred--;
    if (pop) mcred++;
    @(posedge clk);
    #1;
    chk("count", bus.count, q.size());
    chk("out_vld", bus.out_vld, q.size() != 0);
    chk("issue_rdy", bus.issue_rdy, mcred != 0);
    chk("ovf_err", bus.ovf_err, movf);
    if (q.size() != 0) chk("head", bus.out_data, q[0]);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.arg_issue = 1'b0;
    bus.res_vld = 1'b0;
    bus.res = '0;
    bus.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue_rdy", bus.issue_rdy, 1'b1);
    chk("rst_out_vld", bus.out_vld, 1'b0);
    chk("rst_count", bus.count, 0);
    chk("rst_ovf", bus.ovf_err, 1'b0);
    rst = 1'b0;
    tick();
    // fill: four issues, results arrive nine cycles after the first
    bus.arg_issue = 1'b1;
    repeat (4) tick();
    bus.arg_issue = 1'b0;
    chk("no_credit_rdy", bus.issue_rdy, 1'b0);
    repeat (5) tick();
    bus.res_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.res = 32'h11 + W'(i);
      tick();
    end
    bus.res_vld = 1'b0;
    chk("full_count", bus.count, 4);
    chk("full_head", bus.out_data, 32'h11);
    repeat (3) tick();
    chk("held_head", bus.out_data, 32'h11);
    // pop with an issue attempt while no credit: issue ignored, pop frees one credit
    bus.out_rdy = 1'b1;
    bus.arg_issue = 1'b1;
    tick();
    bus.out_rdy = 1'b0;
    bus.arg_issue = 1'b0;
    chk("after_pop_count", bus.count, 3);
    chk("after_pop_head", bus.out_data, 32'h12);
    bus.arg_issue = 1'b1;
    tick();
    bus.arg_issue = 1'b0;
    chk("reissue_rdy", bus.issue_rdy, 1'b0);
    bus.res_vld = 1'b1;
    bus.res = 32'h15;
    tick();
    bus.res_vld = 1'b0;
    chk("refill_count", bus.count, 4);
    // push into a full buffer without a pop is dropped
    bus.res_vld = 1'b1;
    bus.res = 32'h99;
    tick();
    bus.res_vld = 1'b0;
    chk("ovf_flag", bus.ovf_err, OVF);
    chk("ovf_head", bus.out_data, 32'h12);
    chk("ovf_count", bus.count, 4);
    repeat (2) tick();
    chk("ovf_sticky", bus.ovf_err, OVF);
    bus.out_rdy = 1'b1;
    repeat (4) tick();
    bus.out_rdy = 1'b0;
    chk("drained_count", bus.count, 0);
    chk("drained_rdy", bus.issue_rdy, 1'b1);
    // single result into an empty buffer: visible exactly one cycle later
    bus.arg_issue = 1'b1;
    tick();
    bus.arg_issue = 1'b0;
    bus.res_vld = 1'b1;
    bus.res = 32'hABCD;
    bus.out_rdy = 1'b1;
    #1;
    chk("no_bypass", bus.out_vld, 1'b0);
    tick();
    bus.res_vld = 1'b0;
    chk("lat_vld", bus.out_vld, 1'b1);
    chk("lat_data", bus.out_data, 32'hABCD);
    tick();
    chk("lat_count", bus.count, 0);
    // streaming: issue every cycle, result one cycle later, consumer always ready
    for (int i = 0; i < 100; i++) begin
      bus.arg_issue = 1'b1;
      bus.res_vld = i > 0;
      bus.res = 32'h1000 + W'(i);
      tick();
      if (int'(bus.count) > maxc) maxc = int'(bus.count);
      if (!bus.issue_rdy) rdy_drop++;
    end
    bus.arg_issue = 1'b0;
    bus.res_vld = 1'b1;
    bus.res = 32'h1000 + 32'd100;
    tick();
    bus.res_vld = 1'b0;
    tick();
    chk("stream_max_count_le1", maxc <= 1, 1'b1);
    chk("stream_rdy_drops", rdy_drop, 0);
    chk("stream_end_count", bus.count, 0);
    // asynchronous reset with one entry stored
    bus.out_rdy = 1'b0;
    bus.arg_issue = 1'b1;
    tick();
    bus.arg_issue = 1'b0;
    bus.res_vld = 1'b1;
    bus.res = 32'h77;
    tick();
    bus.res_vld = 1'b0;
    chk("pre_rst_count", bus.count, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_vld", bus.out_vld, 1'b0);
    chk("async_rst_rdy", bus.issue_rdy, 1'b1);
    chk("async_rst_ovf", bus.ovf_err, 1'b0);
    q.delete();
    mcred = D;
    movf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
